dp_sequencer: RTL
=================

// Module: dp_sequencer
// PURPOSE
//  Fetch/decode/execute FSM that sequences the 8-bit accumulator datapath.
//  Reads 1- or 2-byte instructions from an async-read program ROM and drives every datapath
//  control input (mux, acc/rf write, rf addr, ALU, shifter, out enable, immediate).
//  Samples the zero/positive flags for conditional jumps.
//  Exchanges input bytes via a valid/ready handshake.
// PARAMETERS
//  PC_W  8  program counter / ROM address width; jump target = imm[PC_W-1:0]
// PORTS
//  clk_seq      in   1     clock, all state on rising edge
//  rst_n_seq    in   1     asynchronous, active-low reset
//  run_seq      in   1     1 = execute; 0 = hold in FETCH, pc frozen
//  pc_seq       out  PC_W  ROM address
//  instr_seq    in   8     ROM data, valid same cycle as pc_seq
//  in_valid_seq in   1     input byte on datapath input_dp is valid
//  in_ready_seq out  1     input byte consumed this cycle
//  zero_dp      in   1     datapath flag (mux output == 0)
//  positive_dp  in   1     datapath flag (~mux output[7])
//  muxsel_dp    out  2     00 shifter, 01 rf, 10 input, 11 imm
//  imm_dp       out  8     immediate register (IMR)
//  accwr_dp / rfwr_dp / outen_dp  out 1 each  write/output strobes
//  rfaddr_dp    out  3     register select = IR[2:0]
//  alusel_dp    out  3     ALU op
//  shiftsel_dp  out  2     00 pass, 01 shl, 10 shr, 11 rotr
//  halted_seq   out  1     HALT executed
// BEHAVIOUR
//  Encoding IR[7:4] op, IR[3] var, IR[2:0] r/s. 2-byte ops (second byte -> IMR): LDI,JMP,JZ,JP.
//   0 NOP | 1 LDA A<-R[r] | 2 STA R[r]<-A | 3 LDI A<-imm | 4 JMP | 5 JZ | 6 JP (A>=0)
//   7 ADD | 8 SUB | 9 AND | A OR (A op R[r]) | B NOT | C var0 INC, var1 DEC
//   D SHIFT s=IR[1:0] | E IN | F var0 OUT, var1 HALT
//  States: FETCH -> DECODE -> (FETCH2 if 2-byte) -> EXEC | INWAIT | HALT; EXEC/INWAIT -> FETCH.
//   FETCH:  IR<=instr_seq; pc<=pc+1 (if run_seq=1, else hold)
//   FETCH2: IMR<=instr_seq; pc<=pc+1
//   EXEC:   one cycle of control strobes; 1-byte ops = 3 cycles, 2-byte = 4
//  EXEC control words (unlisted outputs 0):
//   LDA muxsel=01 accwr=1 | STA rfwr=1 | LDI muxsel=11 accwr=1
//   ALU ops muxsel=00 shiftsel=00 accwr=1, alusel ADD001 SUB010 AND011 OR100 NOT101 INC110 DEC111
//   SHIFT muxsel=00 alusel=000 shiftsel=s accwr=1 | OUT outen=1
//   JZ/JP muxsel=00 alusel=000 shiftsel=00 (mux=A); pc<=IMR if zero_dp / positive_dp, else keep
//   JMP pc<=IMR unconditionally
//  INWAIT (op E, entered from DECODE): muxsel=10; accwr_dp = in_ready_seq = in_valid_seq
//   (Mealy, same cycle); transfer -> FETCH, else stay. Only in_valid_seq->output comb path.
//  HALT: all strobes 0, pc frozen, halted_seq=1; exit only by reset. run_seq ignored after FETCH.
//  Strobes are comb from state+IR/IMR; zero outside EXEC/INWAIT.
//  pc arithmetic mod 2^PC_W (max wraps to 0); jump to own address legal.
//  Reset (any state, mid-handshake included): immediately state=FETCH, pc=0, IR=0, IMR=0,
//   all strobes/muxsel/alusel/shiftsel/rfaddr/imm = 0, in_ready=0, halted=0.
//  Undefined var bits (e.g. NOP IR[3:0]) ignored.
// STRUCTURE
//  seq_pkg: opcode, state encoding, muxsel/alusel/shiftsel code localparams (shared with bench).
//  Sub-module seq_decoder: comb {state,IR} -> control word + is_2byte flag; top holds FSM/pc/IR/IMR.
// TESTING
//  1 ROM: LDI 05; STA R3; LDI 0A; ADD R3; OUT; HALT -> output_dp=0x0F while outen, halted=1, pc const
//  2 LDI 00; JZ 10 -> pc=0x10; LDI 80; JP 20 -> not taken, pc=next sequential
//  3 IN, in_valid low 5 cyc -> INWAIT held, accwr=0; in_valid=1 data 3C -> accwr=in_ready=1 1 cyc, A=3C
//  4 JMP FF, NOP at FF -> next fetch at pc 00 (wrap)
//  5 rst_n_seq low during INWAIT / EXEC -> all outputs 0 same cycle, pc=0, restart at FETCH
//  6 LDI 81; SHIFT s=11 -> A=C0; SHIFT s=01 -> A=80; DEC -> A=7F

Source files
------------

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pkg
// Brief    : Opcodes, FSM state codes and datapath control codes for the
//            accumulator-datapath sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package seq_pkg;

    localparam logic [3:0] c_OP_NOP   = 4'h0;
    localparam logic [3:0] c_OP_LDA   = 4'h1;
    localparam logic [3:0] c_OP_STA   = 4'h2;
    localparam logic [3:0] c_OP_LDI   = 4'h3;
    localparam logic [3:0] c_OP_JMP   = 4'h4;
    localparam logic [3:0] c_OP_JZ    = 4'h5;
    localparam logic [3:0] c_OP_JP    = 4'h6;
    localparam logic [3:0] c_OP_ADD   = 4'h7;
    localparam logic [3:0] c_OP_SUB   = 4'h8;
    localparam logic [3:0] c_OP_AND   = 4'h9;
    localparam logic [3:0] c_OP_OR    = 4'hA;
    localparam logic [3:0] c_OP_NOT   = 4'hB;
    localparam logic [3:0] c_OP_INC   = 4'hC;
    localparam logic [3:0] c_OP_SHIFT = 4'hD;
    localparam logic [3:0] c_OP_IN    = 4'hE;
    localparam logic [3:0] c_OP_OUT   = 4'hF;

    typedef logic [2:0] state_t;
    localparam state_t c_ST_FETCH  = 3'd0;
    localparam state_t c_ST_DECODE = 3'd1;
    localparam state_t c_ST_FETCH2 = 3'd2;
    localparam state_t c_ST_EXEC   = 3'd3;
    localparam state_t c_ST_INWAIT = 3'd4;
    localparam state_t c_ST_HALT   = 3'd5;

    localparam logic [1:0] c_MUX_SHIFT = 2'b00;
    localparam logic [1:0] c_MUX_RF    = 2'b01;
    localparam logic [1:0] c_MUX_INPUT = 2'b10;
    localparam logic [1:0] c_MUX_IMM   = 2'b11;

    localparam logic [2:0] c_ALU_PASS = 3'b000;
    localparam logic [2:0] c_ALU_ADD  = 3'b001;
    localparam logic [2:0] c_ALU_SUB  = 3'b010;
    localparam logic [2:0] c_ALU_AND  = 3'b011;
    localparam logic [2:0] c_ALU_OR   = 3'b100;
    localparam logic [2:0] c_ALU_NOT  = 3'b101;
    localparam logic [2:0] c_ALU_INC  = 3'b110;
    localparam logic [2:0] c_ALU_DEC  = 3'b111;

    localparam logic [1:0] c_SHF_PASS = 2'b00;
    localparam logic [1:0] c_SHF_SHL  = 2'b01;
    localparam logic [1:0] c_SHF_SHR  = 2'b10;
    localparam logic [1:0] c_SHF_ROTR = 2'b11;

    typedef struct packed {
        logic [1:0] muxsel;
        logic       accwr;
        logic       rfwr;
        logic       outen;
        logic [2:0] rfaddr;
        logic [2:0] alusel;
        logic [1:0] shiftsel;
        logic       in_ready;
    } ctrl_t;

    // Opcodes carrying an immediate byte that is fetched into IMR.
    function automatic logic is_two_byte(input logic [3:0] op);
        return (op == c_OP_LDI) || (op == c_OP_JMP) ||
               (op == c_OP_JZ)  || (op == c_OP_JP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seq_decoder
// Brief    : Combinational control-word decode from FSM state and IR.
// Revision : 1.0 - initial release
// ============================================================================
module seq_decoder
    import seq_pkg::*;
(
    input  state_t     i_state,
    input  logic [7:0] i_ir,
    input  logic       i_in_valid,
    output ctrl_t      o_ctrl,
    output logic       o_two_byte
);

    logic [3:0] w_op;
    logic       w_var;

    assign w_op       = i_ir[7:4];
    assign w_var      = i_ir[3];
    assign o_two_byte = is_two_byte(w_op);

    always_comb begin
        o_ctrl = '0;
        if (i_state == c_ST_EXEC) begin
            case (w_op)
                c_OP_LDA: begin
                    o_ctrl.muxsel = c_MUX_RF;
                    o_ctrl.accwr  = 1'b1;
                    o_ctrl.rfaddr = i_ir[2:0];
                end
                c_OP_STA: begin
                    o_ctrl.rfwr   = 1'b1;
                    o_ctrl.rfaddr = i_ir[2:0];
                end
                c_OP_LDI: begin
                    o_ctrl.muxsel = c_MUX_IMM;
                    o_ctrl.accwr  = 1'b1;
                end
                c_OP_ADD: begin
                    o_ctrl.alusel = c_ALU_ADD;
                    o_ctrl.accwr  = 1'b1;
                    o_ctrl.rfaddr = i_ir[2:0];
                end
                c_OP_SUB: begin
                    o_ctrl.alusel = c_ALU_SUB;
                    o_ctrl.accwr  = 1'b1;
                    o_ctrl.rfaddr = i_ir[2:0];
                end
                c_OP_AND: begin
                    o_ctrl.alusel = c_ALU_AND;
                    o_ctrl.accwr  = 1'b1;
                    o_ctrl.rfaddr = i_ir[2:0];
                end
                c_OP_OR: begin
                    o_ctrl.alusel = c_ALU_OR;
                    o_ctrl.accwr  = 1'b1;
                    o_ctrl.rfaddr = i_ir[2:0];
                end
                c_OP_NOT: begin
                    o_ctrl.alusel = c_ALU_NOT;
                    o_ctrl.accwr  = 1'b1;
                end
                c_OP_INC: begin
                    o_ctrl.alusel = w_var ? c_ALU_DEC : c_ALU_INC;
                    o_ctrl.accwr  = 1'b1;
                end
                c_OP_SHIFT: begin
                    o_ctrl.shiftsel = i_ir[1:0];
                    o_ctrl.accwr    = 1'b1;
                end
                c_OP_OUT: begin
                    o_ctrl.outen = ~w_var;
                end
                // JZ/JP leave the word at zero so the mux presents A to the flags.
                default: ;
            endcase
        end else if (i_state == c_ST_INWAIT) begin
            o_ctrl.muxsel   = c_MUX_INPUT;
            o_ctrl.accwr    = i_in_valid;
            o_ctrl.in_ready = i_in_valid;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dp_sequencer
// Brief    : Fetch/decode/execute FSM sequencing the 8-bit accumulator datapath.
// Revision : 1.0 - initial release
// ============================================================================
module dp_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk_seq,
    input  logic            rst_n_seq,
    input  logic            run_seq,
    output logic [PC_W-1:0] pc_seq,
    input  logic [7:0]      instr_seq,
    input  logic            in_valid_seq,
    output logic            in_ready_seq,
    input  logic            zero_dp,
    input  logic            positive_dp,
    output logic [1:0]      muxsel_dp,
    output logic [7:0]      imm_dp,
    output logic            accwr_dp,
    output logic            rfwr_dp,
    output logic            outen_dp,
    output logic [2:0]      rfaddr_dp,
    output logic [2:0]      alusel_dp,
    output logic [1:0]      shiftsel_dp,
    output logic            halted_seq
);

    localparam logic [PC_W-1:0] c_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_target;
    logic [7:0]      r_ir;
    logic [7:0]      r_imr;
    logic            w_ir_ld;
    logic            w_imr_ld;
    logic [3:0]      w_op;
    logic            w_two_byte;
    ctrl_t           w_ctrl;

    assign w_op     = r_ir[7:4];
    assign w_target = r_imr[PC_W-1:0];

    seq_decoder u_decoder (
        .i_state    (r_state),
        .i_ir       (r_ir),
        .i_in_valid (in_valid_seq),
        .o_ctrl     (w_ctrl),
        .o_two_byte (w_two_byte)
    );

    always_ff @(posedge clk_seq or negedge rst_n_seq) begin
        if (!rst_n_seq) begin
            r_state <= c_ST_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
            r_imr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_ir_ld) begin
                r_ir <= instr_seq;
            end
            if (w_imr_ld) begin
                r_imr <= instr_seq;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_ld     = 1'b0;
        w_imr_ld    = 1'b0;
        case (r_state)
            c_ST_FETCH: begin
                if (run_seq) begin
                    w_ir_ld     = 1'b1;
                    w_pc_nxt    = r_pc + c_PC_ONE;
                    w_state_nxt = c_ST_DECODE;
                end
            end
            c_ST_DECODE: begin
                if (w_two_byte) begin
                    w_state_nxt = c_ST_FETCH2;
                end else if (w_op == c_OP_IN) begin
                    w_state_nxt = c_ST_INWAIT;
                end else if ((w_op == c_OP_OUT) && r_ir[3]) begin
                    w_state_nxt = c_ST_HALT;
                end else begin
                    w_state_nxt = c_ST_EXEC;
                end
            end
            c_ST_FETCH2: begin
                w_imr_ld    = 1'b1;
                w_pc_nxt    = r_pc + c_PC_ONE;
                w_state_nxt = c_ST_EXEC;
            end
            c_ST_EXEC: begin
                w_state_nxt = c_ST_FETCH;
                // Flags reflect A here because the exec word routes A through the mux.
                if ((w_op == c_OP_JMP) ||
                    ((w_op == c_OP_JZ) && zero_dp) ||
                    ((w_op == c_OP_JP) && positive_dp)) begin
                    w_pc_nxt = w_target;
                end
            end
            c_ST_INWAIT: begin
                if (in_valid_seq) begin
                    w_state_nxt = c_ST_FETCH;
                end
            end
            c_ST_HALT: ;
            default: w_state_nxt = c_ST_FETCH;
        endcase
    end

    assign pc_seq       = r_pc;
    assign imm_dp       = r_imr;
    assign muxsel_dp    = w_ctrl.muxsel;
    assign accwr_dp     = w_ctrl.accwr;
    assign rfwr_dp      = w_ctrl.rfwr;
    assign outen_dp     = w_ctrl.outen;
    assign rfaddr_dp    = w_ctrl.rfaddr;
    assign alusel_dp    = w_ctrl.alusel;
    assign shiftsel_dp  = w_ctrl.shiftsel;
    assign in_ready_seq = w_ctrl.in_ready;
    assign halted_seq   = (r_state == c_ST_HALT);

endmodule
`default_nettype wire
